inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
//  Fetch-side initiator and buffer for the instruction cache. Drives the line-fetch PC and read request,
//  captures each 4-word line returned on Cache_ReadHit into a line FIFO, and hands instructions to
//  dispatch one word per cycle. Handles redirects (jump/branch from dispatch, flush from CDB) by
//  emptying the queue, pulsing IFQ_Flush to the cache and restarting fetch at the target line.
// PARAMETERS
//  DEPTH_LINES  4        line FIFO depth in 128-bit lines (power of 2, >=2)
//  RESET_PC     32'h0    first fetch address after reset (word aligned)
// PORTS
//  Clk              in   1    core clock
//  Resetb           in   1    asynchronous, active-low reset
//  Ifetch_WpPcIn    out  32   line fetch address to cache; bits[3:0] always 0
//  Ifetch_ReadCache out  1    read request, level; =!full
//  IFQ_Flush        out  1    one-cycle pulse: cache abandons in-flight read
//  Cache_Cd0..Cd3   in   32   line words 0..3 (Cd0 = lowest address)
//  Cache_ReadHit    in   1    line valid this cycle
//  Dis_Ren          in   1    dispatch consumes IFQ_Inst this cycle
//  Dis_JmpBr        in   1    dispatch redirect request
//  Dis_JmpBrAddr    in   32   dispatch redirect target
//  Cdb_Flush        in   1    back-end flush redirect (priority over Dis_JmpBr)
//  Rob_FlushAddr    in   32   back-end redirect target
//  IFQ_Inst         out  32   instruction at head
//  IFQ_PC           out  32   PC of IFQ_Inst
//  IFQ_EmptyFlag    out  1    no valid instruction at head
// BEHAVIOUR
//  Reset: Ifetch_WpPcIn=RESET_PC, IFQ_PC=RESET_PC, wr/rd ptr=0, rd_word=RESET_PC[3:2],
//   IFQ_EmptyFlag=1, IFQ_Flush=0, Ifetch_ReadCache=1, IFQ_Inst=0.
//  Pointers: wr_ptr/rd_ptr are log2(DEPTH_LINES)+1 bits; empty = equal; full = MSB differ, rest equal.
//  Fill: Cache_ReadHit & !redirect -> line written at wr_ptr, wr_ptr++, Ifetch_WpPcIn += 16 (wraps 2^32).
//  Drain: IFQ_Inst = line[rd_ptr] word rd_word (combinational). Dis_Ren & !empty & !redirect ->
//   IFQ_PC += 4; rd_word==3 -> rd_word=0, rd_ptr++; else rd_word++. Dis_Ren while empty ignored.
//  Fill and drain in the same cycle both take effect; the queue holds exactly DEPTH_LINES lines.
//  Full: Ifetch_ReadCache=0; no hit can occur (cache requires request).
//  Redirect (Cdb_Flush | Dis_JmpBr) in cycle t, target T = Rob_FlushAddr if Cdb_Flush else Dis_JmpBrAddr:
//   IFQ_Flush=1 combinationally in t; hit and Dis_Ren in t discarded; at t+1: ptrs=0,
//   Ifetch_WpPcIn={T[31:4],4'b0}, rd_word=T[3:2], IFQ_PC=T, EmptyFlag=1.
//   First line after redirect: words below rd_word skipped (drain starts at T).
//  Back-to-back redirects: each restarts from its own target; last one wins.
//  Reset mid-fetch: all state returns to reset values regardless of outstanding cache read.
// CONFIGURATION
//  IFQ_BYPASS_EN defined: when empty and Cache_ReadHit (no redirect), IFQ_Inst = Cache_Cd[rd_word]
//   and IFQ_EmptyFlag=0 in the same cycle; Dis_Ren then consumes it while the line is still written
//   (rd_word advances; if word 3 consumed, rd_ptr advances too).
//  Undefined: returned line is visible to dispatch one cycle after Cache_ReadHit.
// STRUCTURE
//  ifq_pkg: LINE_W=128, WORD_W=32, WORDS_PER_LINE=4, LINE_OFS_W=4, typedef line_t, word_sel_t.
//  Sub-module ifq_word_sel: 4:1 word mux (line_t, word_sel_t -> word), used for head and bypass paths.
//  Storage is a register array (DEPTH_LINES x 128); no block RAM.
// TESTING
//  1 Reset, cache returns lines for 0x00,0x10 -> WpPc 0x00->0x10->0x20; IFQ_PC 0,4,8,.. with Dis_Ren=1.
//  2 Dis_Ren=0, 4 hits -> full, Ifetch_ReadCache=0, WpPc=0x40; one Dis_Ren pops word, still full until 4th.
//  3 Dis_JmpBr=1, addr 0x0000_0128 -> IFQ_Flush pulse 1 cycle, WpPc=0x120, first IFQ_PC=0x128, inst = Cd2.
//  4 Cdb_Flush (0x200) and Dis_JmpBr (0x300) same cycle, hit also asserted -> target 0x200, hit dropped.
//  5 WpPc=0xFFFF_FFF0 hit -> wraps to 0x0000_0000; IFQ_PC wraps 0xFFFF_FFFC -> 0.
//  6 Resetb low during pending read with 2 lines queued -> EmptyFlag=1, WpPc=RESET_PC next edge.

Source files
------------

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and helpers for the instruction fetch queue.
//   LINE_W / WORD_W / WORDS_PER_LINE / LINE_OFS_W : cache line geometry
//   line_t     : one 128-bit cache line, word 0 in bits [31:0] (lowest address)
//   word_sel_t : index of a word inside a line
//   line_base  : clears the byte-in-line offset of an address
//   word_of    : word index of an address inside its line
package ifq_pkg;
    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_OFS_W     = 4;

    typedef logic [LINE_W-1:0]                  line_t;
    typedef logic [$clog2(WORDS_PER_LINE)-1:0]  word_sel_t;

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
    endfunction

    function automatic word_sel_t word_of(input logic [31:0] addr);
        return addr[3:2];
    endfunction
endpackage

// File: rtl/ifq_word_sel.sv
// ifq_word_sel: 4:1 word multiplexer over one cache line.
//   line : cache line, word 0 in the least significant 32 bits
//   sel  : word index
//   word : selected 32-bit word
module ifq_word_sel
    import ifq_pkg::*;
(
    input  line_t             line,
    input  word_sel_t         sel,
    output logic [WORD_W-1:0] word
);
    always_comb begin
        word = line[WORD_W-1:0];
        case (sel)
            2'd0: word = line[1*WORD_W-1:0*WORD_W];
            2'd1: word = line[2*WORD_W-1:1*WORD_W];
            2'd2: word = line[3*WORD_W-1:2*WORD_W];
            2'd3: word = line[4*WORD_W-1:3*WORD_W];
            default: word = line[WORD_W-1:0];
        endcase
    end
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch initiator and line buffer.
// Requests cache lines, stores returned lines in a DEPTH_LINES-deep FIFO of
// 128-bit lines and presents one instruction per cycle to dispatch. A redirect
// (Cdb_Flush has priority over Dis_JmpBr) empties the queue, pulses IFQ_Flush
// and restarts fetch at the target line.
//
// Ports:
//   Clk, Resetb           : clock, asynchronous active-low reset
//   Ifetch_WpPcIn         : line fetch address (bits [3:0] always zero)
//   Ifetch_ReadCache      : read request level, high whenever the FIFO is not full
//   IFQ_Flush             : combinational pulse in the redirect cycle
//   Cache_Cd0..Cache_Cd3  : returned line words (Cd0 = lowest address)
//   Cache_ReadHit         : returned line valid this cycle
//   Dis_Ren               : dispatch consumes IFQ_Inst this cycle
//   Dis_JmpBr/_JmpBrAddr  : dispatch redirect and target
//   Cdb_Flush/Rob_FlushAddr : back-end redirect and target
//   IFQ_Inst, IFQ_PC      : head instruction and its PC
//   IFQ_EmptyFlag         : no valid instruction at the head
//
// Handshakes: a line transfers when Cache_ReadHit is high, which the cache only
// does while Ifetch_ReadCache is high; an instruction transfers when Dis_Ren is
// high and IFQ_EmptyFlag is low. A redirect in the same cycle cancels both.
//
// Build option: define IFQ_BYPASS_EN to present a returning line to dispatch in
// the same cycle when the queue is empty; otherwise a line becomes visible one
// cycle after Cache_ReadHit.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH_LINES = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
)(
    input  logic        Clk,
    input  logic        Resetb,
    output logic [31:0] Ifetch_WpPcIn,
    output logic        Ifetch_ReadCache,
    output logic        IFQ_Flush,
    input  logic [31:0] Cache_Cd0,
    input  logic [31:0] Cache_Cd1,
    input  logic [31:0] Cache_Cd2,
    input  logic [31:0] Cache_Cd3,
    input  logic        Cache_ReadHit,
    input  logic        Dis_Ren,
    input  logic        Dis_JmpBr,
    input  logic [31:0] Dis_JmpBrAddr,
    input  logic        Cdb_Flush,
    input  logic [31:0] Rob_FlushAddr,
    output logic [31:0] IFQ_Inst,
    output logic [31:0] IFQ_PC,
    output logic        IFQ_EmptyFlag
);
    localparam int PTR_W = $clog2(DEPTH_LINES);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    word_sel_t         rd_word;
    logic [31:0]       wp_pc;
    logic [31:0]       head_pc;
    line_t             lines [DEPTH_LINES];

    logic              redirect;
    logic [31:0]       target;
    logic              empty;
    logic              full;
    logic              fill;
    logic              drain;
    line_t             cd_line;
    line_t             head_line;
    logic [WORD_W-1:0] head_word;

    assign redirect = Cdb_Flush | Dis_JmpBr;
    assign target   = Cdb_Flush ? Rob_FlushAddr : Dis_JmpBrAddr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // The cache never hits without a request; the !full term only keeps a
    // misbehaving cache from overwriting unread lines.
    assign fill     = Cache_ReadHit & ~redirect & ~full;
    assign cd_line  = {Cache_Cd3, Cache_Cd2, Cache_Cd1, Cache_Cd0};
    assign head_line = lines[rd_ptr[PTR_W-1:0]];

    ifq_word_sel u_head_sel (
        .line (head_line),
        .sel  (rd_word),
        .word (head_word)
    );

`ifdef IFQ_BYPASS_EN
    logic [WORD_W-1:0] bypass_word;
    logic              bypass;

    ifq_word_sel u_bypass_sel (
        .line (cd_line),
        .sel  (rd_word),
        .word (bypass_word)
    );

    // An empty queue forwards the arriving line directly; the line is still
    // written, so a consumed bypass word simply advances the read position.
    assign bypass        = empty & fill;
    assign IFQ_Inst      = bypass ? bypass_word : head_word;
    assign IFQ_EmptyFlag = empty & ~bypass;
`else
    assign IFQ_Inst      = head_word;
    assign IFQ_EmptyFlag = empty;
`endif

    assign drain            = Dis_Ren & ~IFQ_EmptyFlag & ~redirect;
    assign IFQ_Flush        = redirect;
    assign Ifetch_ReadCache = ~full;
    assign Ifetch_WpPcIn    = wp_pc;
    assign IFQ_PC           = head_pc;

    // Pointers, fetch address and head PC.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_word <= word_of(RESET_PC);
            wp_pc   <= line_base(RESET_PC);
            head_pc <= RESET_PC;
        end else if (redirect) begin
            // Starting rd_word at the target's word skips the lower words of
            // the first returned line.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_word <= word_of(target);
            wp_pc   <= line_base(target);
            head_pc <= target;
        end else begin
            if (fill) begin
                wr_ptr <= wr_ptr + 1'b1;
                wp_pc  <= wp_pc + 32'd16;
            end
            if (drain) begin
                head_pc <= head_pc + 32'd4;
                if (rd_word == word_sel_t'(WORDS_PER_LINE - 1)) begin
                    rd_word <= '0;
                    rd_ptr  <= rd_ptr + 1'b1;
                end else begin
                    rd_word <= rd_word + 1'b1;
                end
            end
        end
    end

    // Line storage; cleared on reset so IFQ_Inst reads zero out of reset.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            for (int i = 0; i < DEPTH_LINES; i++) begin
                lines[i] <= '0;
            end
        end else if (fill) begin
            lines[wr_ptr[PTR_W-1:0]] <= cd_line;
        end
    end
endmodule
